// File: rtl/load_store_unit.sv
// Load/store unit: turns RV32I load/store requests into single-beat memory bus
// transactions, stalling the core until the bus acknowledges.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic        we;
  } req_t;

  state_t state_q, state_d;
  req_t   req_q;
  logic   f3_ok, aligned, any_req, legal_req;
  logic [15:0] lane;
  logic [31:0] load_val;

  // Unsigned variants (funct3[2]) exist only for byte/halfword loads.
  always_comb begin
    f3_ok   = (funct3[1:0] != 2'b11) && !(funct3[2] && (funct3[1] || mem_write));
    aligned = 1'b0;
    case (funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    any_req   = mem_read | mem_write;
    legal_req = (mem_read ^ mem_write) && f3_ok && aligned;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (legal_req) state_d = ACCESS;
      ACCESS:  if (bus_ready) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall   = ((state_q == IDLE) && legal_req) || (state_q == ACCESS);
    err     = (state_q == IDLE) && any_req && !legal_req;
    bus_req = (state_q == ACCESS);
    done    = (state_q == RESP);
  end

  // Bus-side lane steering, all from the captured request so it holds steady.
  always_comb begin
    bus_we   = req_q.we;
    bus_addr = {req_q.addr[31:2], 2'b00};
    case (req_q.funct3[1:0])
      2'b00: begin
        bus_be    = 4'b0001 << req_q.addr[1:0];
        bus_wdata = {4{req_q.wdata[7:0]}};
      end
      2'b01: begin
        bus_be    = req_q.addr[1] ? 4'b1100 : 4'b0011;
        bus_wdata = {2{req_q.wdata[15:0]}};
      end
      default: begin
        bus_be    = 4'b1111;
        bus_wdata = req_q.wdata;
      end
    endcase
  end

  always_comb begin
    case (req_q.addr[1:0])
      2'b00:   lane = bus_rdata[15:0];
      2'b01:   lane = {8'h00, bus_rdata[15:8]};
      2'b10:   lane = bus_rdata[31:16];
      default: lane = {8'h00, bus_rdata[31:24]};
    endcase
    case (req_q.funct3)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane};
      3'b100:  load_val = {24'h0, lane[7:0]};
      3'b101:  load_val = {16'h0, lane};
      default: load_val = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q <= '0;
      rdata <= '0;
    end else begin
      if (state_q == IDLE && legal_req)
        req_q <= '{addr: addr, wdata: wdata, funct3: funct3, we: mem_write};
      if (state_q == ACCESS && bus_ready && !req_q.we)
        rdata <= load_val;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: per-scenario tasks with hand-computed
// expected bus and load results.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, err;
  logic [31:0] rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int total  = 0;
  int passed = 0;

  load_store_unit dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
    .done(done), .err(err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus_req !== 1'b0) $display("FAIL rst_bus_req got %0b exp 0", bus_req); else passed++;
    total++; if (done !== 1'b0) $display("FAIL rst_done got %0b exp 0", done); else passed++;
    total++; if (rdata !== 32'h0) $display("FAIL rst_rdata got %h exp 0", rdata); else passed++;
    total++; if (bus_addr !== 32'h0) $display("FAIL rst_bus_addr got %h exp 0", bus_addr); else passed++;
    total++; if (bus_wdata !== 32'h0) $display("FAIL rst_bus_wdata got %h exp 0", bus_wdata); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL rst_stall got %0b exp 0", stall); else passed++;
    reset = 1'b0;
    tick();
    total++; if (bus_req !== 1'b0) $display("FAIL rst_idle_req got %0b exp 0", bus_req); else passed++;
  endtask

  task automatic test_lw();
    drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    #1;
    total++; if (stall !== 1'b1) $display("FAIL lw_stall_c0 got %0b exp 1", stall); else passed++;
    total++; if (bus_req !== 1'b0) $display("FAIL lw_req_c0 got %0b exp 0", bus_req); else passed++;
    tick();
    total++; if (bus_req !== 1'b1) $display("FAIL lw_req_c1 got %0b exp 1", bus_req); else passed++;
    total++; if (bus_addr !== 32'h100) $display("FAIL lw_addr got %h exp 00000100", bus_addr); else passed++;
    total++; if (bus_be !== 4'b1111) $display("FAIL lw_be got %b exp 1111", bus_be); else passed++;
    total++; if (bus_we !== 1'b0) $display("FAIL lw_we got %0b exp 0", bus_we); else passed++;
    total++; if (stall !== 1'b1) $display("FAIL lw_stall_c1 got %0b exp 1", stall); else passed++;
    bus_ready = 1'b1;
    bus_rdata = 32'hDEADBEEF;
    tick();
    bus_ready = 1'b0;
    total++; if (done !== 1'b1) $display("FAIL lw_done got %0b exp 1", done); else passed++;
    total++; if (rdata !== 32'hDEADBEEF) $display("FAIL lw_rdata got %h exp deadbeef", rdata); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL lw_stall_c2 got %0b exp 0", stall); else passed++;
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    total++; if (done !== 1'b0) $display("FAIL lw_done_c3 got %0b exp 0", done); else passed++;
  endtask

  task automatic test_lb_lbu();
    drive(1'b1, 1'b0, 3'b000, 32'h203, 32'h0);
    tick();
    total++; if (bus_be !== 4'b1000) $display("FAIL lb_be got %b exp 1000", bus_be); else passed++;
    total++; if (bus_addr !== 32'h200) $display("FAIL lb_addr got %h exp 00000200", bus_addr); else passed++;
    bus_ready = 1'b1;
    bus_rdata = 32'h80FFFF7F;
    tick();
    bus_ready = 1'b0;
    total++; if (rdata !== 32'hFFFFFF80) $display("FAIL lb_rdata got %h exp ffffff80", rdata); else passed++;
    tick();
    drive(1'b1, 1'b0, 3'b100, 32'h203, 32'h0);
    tick();
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    total++; if (done !== 1'b1) $display("FAIL lbu_done got %0b exp 1", done); else passed++;
    total++; if (rdata !== 32'h00000080) $display("FAIL lbu_rdata got %h exp 00000080", rdata); else passed++;
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic test_sh_wait();
    int stall_cycles = 0;
    drive(1'b0, 1'b1, 3'b001, 32'h12, 32'h0000ABCD);
    #1;
    if (stall) stall_cycles++;
    tick();
    total++; if (bus_be !== 4'b1100) $display("FAIL sh_be got %b exp 1100", bus_be); else passed++;
    total++; if (bus_wdata !== 32'hABCDABCD) $display("FAIL sh_wdata got %h exp abcdabcd", bus_wdata); else passed++;
    total++; if (bus_we !== 1'b1) $display("FAIL sh_we got %0b exp 1", bus_we); else passed++;
    total++; if (bus_addr !== 32'h10) $display("FAIL sh_addr got %h exp 00000010", bus_addr); else passed++;
    if (stall) stall_cycles++;
    tick();
    total++; if (bus_req !== 1'b1 || done !== 1'b0) $display("FAIL sh_wait req=%0b done=%0b exp req=1 done=0", bus_req, done); else passed++;
    if (stall) stall_cycles++;
    tick();
    bus_ready = 1'b1;
    #1;
    if (stall) stall_cycles++;
    tick();
    // bus_ready left high into RESP and IDLE must not matter
    total++; if (done !== 1'b1) $display("FAIL sh_done got %0b exp 1", done); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL sh_stall_resp got %0b exp 0", stall); else passed++;
    total++; if (stall_cycles !== 4) $display("FAIL sh_stall_cycles got %0d exp 4", stall_cycles); else passed++;
    total++; if (rdata !== 32'h00000080) $display("FAIL sh_rdata_kept got %h exp 00000080", rdata); else passed++;
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    total++; if (done !== 1'b0 || bus_req !== 1'b0) $display("FAIL sh_idle done=%0b req=%0b exp 0 0", done, bus_req); else passed++;
    tick();
    total++; if (done !== 1'b0 || bus_req !== 1'b0) $display("FAIL stray_ready done=%0b req=%0b exp 0 0", done, bus_req); else passed++;
    bus_ready = 1'b0;
  endtask

  task automatic test_err();
    drive(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
    #1;
    total++; if (err !== 1'b1) $display("FAIL err_lw_mis got %0b exp 1", err); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL err_lw_stall got %0b exp 0", stall); else passed++;
    tick();
    total++; if (bus_req !== 1'b0) $display("FAIL err_lw_req got %0b exp 0", bus_req); else passed++;
    drive(1'b0, 1'b1, 3'b001, 32'h7, 32'h0);
    #1;
    total++; if (err !== 1'b1 || stall !== 1'b0) $display("FAIL err_sh_mis err=%0b stall=%0b exp 1 0", err, stall); else passed++;
    tick();
    total++; if (bus_req !== 1'b0) $display("FAIL err_sh_req got %0b exp 0", bus_req); else passed++;
    drive(1'b1, 1'b1, 3'b010, 32'h0, 32'h0);
    #1;
    total++; if (err !== 1'b1 || stall !== 1'b0) $display("FAIL err_both err=%0b stall=%0b exp 1 0", err, stall); else passed++;
    tick();
    total++; if (bus_req !== 1'b0) $display("FAIL err_both_req got %0b exp 0", bus_req); else passed++;
    drive(1'b0, 1'b1, 3'b100, 32'h0, 32'h0);
    #1;
    total++; if (err !== 1'b1) $display("FAIL err_sbu got %0b exp 1", err); else passed++;
    tick();
    total++; if (bus_req !== 1'b0 || done !== 1'b0) $display("FAIL err_sbu_req req=%0b done=%0b exp 0 0", bus_req, done); else passed++;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    total++; if (err !== 1'b0) $display("FAIL err_idle got %0b exp 0", err); else passed++;
  endtask

  task automatic test_reset_in_access();
    drive(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
    tick();
    total++; if (bus_req !== 1'b1) $display("FAIL rsta_req_pre got %0b exp 1", bus_req); else passed++;
    reset    = 1'b1;
    mem_read = 1'b0;
    #1;
    total++; if (bus_req !== 1'b0) $display("FAIL rsta_req_async got %0b exp 0", bus_req); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL rsta_stall got %0b exp 0", stall); else passed++;
    total++; if (rdata !== 32'h0) $display("FAIL rsta_rdata got %h exp 0", rdata); else passed++;
    #1;
    reset     = 1'b0;
    bus_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (done !== 1'b0) $display("FAIL rsta_no_done[%0d] got %0b exp 0", i, done); else passed++;
    end
    bus_ready = 1'b0;
    drive(1'b1, 1'b0, 3'b101, 32'h2, 32'h0);
    tick();
    total++; if (bus_be !== 4'b1100) $display("FAIL lhu_be got %b exp 1100", bus_be); else passed++;
    bus_ready = 1'b1;
    bus_rdata = 32'hF00D0000;
    tick();
    bus_ready = 1'b0;
    total++; if (done !== 1'b1) $display("FAIL lhu_done got %0b exp 1", done); else passed++;
    total++; if (rdata !== 32'h0000F00D) $display("FAIL lhu_rdata got %h exp 0000f00d", rdata); else passed++;
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 3'b000, 32'h5, 32'h123456A5);
    tick();
    total++; if (bus_be !== 4'b0010) $display("FAIL sb_be got %b exp 0010", bus_be); else passed++;
    total++; if (bus_wdata !== 32'hA5A5A5A5) $display("FAIL sb_wdata got %h exp a5a5a5a5", bus_wdata); else passed++;
    total++; if (bus_addr !== 32'h4) $display("FAIL sb_addr got %h exp 00000004", bus_addr); else passed++;
    bus_ready = 1'b1;
    bus_rdata = 32'h11111111;
    tick();
    bus_ready = 1'b0;
    total++; if (done !== 1'b1) $display("FAIL sb_done got %0b exp 1", done); else passed++;
    total++; if (rdata !== 32'h0000F00D) $display("FAIL sb_rdata_kept got %h exp 0000f00d", rdata); else passed++;
    tick();
    drive(1'b1, 1'b0, 3'b001, 32'hA, 32'h0);
    #1;
    total++; if (stall !== 1'b1) $display("FAIL b2b_lh_stall got %0b exp 1", stall); else passed++;
    tick();
    total++; if (bus_be !== 4'b1100 || bus_we !== 1'b0) $display("FAIL b2b_lh_be be=%b we=%0b exp 1100 0", bus_be, bus_we); else passed++;
    bus_ready = 1'b1;
    bus_rdata = 32'h80011234;
    tick();
    bus_ready = 1'b0;
    total++; if (rdata !== 32'hFFFF8001) $display("FAIL b2b_lh_rdata got %h exp ffff8001", rdata); else passed++;
    total++; if (done !== 1'b1) $display("FAIL b2b_lh_done got %0b exp 1", done); else passed++;
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    total++; if (bus_req !== 1'b0 || done !== 1'b0) $display("FAIL b2b_end req=%0b done=%0b exp 0 0", bus_req, done); else passed++;
  endtask

  initial begin
    reset     = 1'b1;
    bus_ready = 1'b0;
    bus_rdata = 32'h0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh_wait();
    test_err();
    test_reset_in_access();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
